// File: rtl/button_conditioner.sv
// Conditions the menu push-buttons into synchronised, debounced levels plus
// single-cycle press/release/repeat events, with one-button-at-a-time ownership.
module button_conditioner #(
  parameter int                 NUM_BTN         = 4,
  parameter int                 DEBOUNCE_CYCLES = 650000,
  parameter int                 HOLD_CYCLES     = 32500000,
  parameter int                 REPEAT_CYCLES   = 6500000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 4'b0011
) (
  input  logic               clk_65mhz,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_held,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic               busy
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HC_W   = (HR_MAX > 1) ? $clog2(HR_MAX) : 1;
  localparam int IDX_W  = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_CYCLES - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  logic [NUM_BTN-1:0] sync_meta;
  logic [NUM_BTN-1:0] sync;
  logic [1:0]         settle;
  logic [NUM_BTN-1:0] armed;
  logic [DB_W-1:0]    cnt [NUM_BTN];
  logic [NUM_BTN-1:0] level_q;

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [HC_W-1:0]    hold_cnt;
  logic               repeating;

  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] fall;
  logic [NUM_BTN-1:0] rise_first;
  logic               rise_any;
  logic [IDX_W-1:0]   rise_idx;
  logic [NUM_BTN-1:0] owner_onehot;

  // A button only becomes armed once its synchronised input has been seen low
  // after reset, so a button held through reset cannot acquire ownership.
  always_ff @(posedge clk_65mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync      <= '0;
      settle    <= '0;
      armed     <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
      settle    <= {settle[0], 1'b1};
      armed     <= armed | ({NUM_BTN{settle[1]}} & ~sync);
    end
  end

  always_ff @(posedge clk_65mhz or negedge rst_n) begin
    if (!rst_n) begin
      btn_level <= '0;
      level_q   <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      level_q <= btn_level;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          btn_level[i] <= sync[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign rise       = btn_level & ~level_q & armed;
  assign fall       = ~btn_level & level_q;
  assign rise_first = rise & (~rise + NUM_BTN'(1));
  assign rise_any   = |rise;

  always_comb begin
    rise_idx     = '0;
    owner_onehot = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (rise[i]) rise_idx = i[IDX_W-1:0];
    end
    for (int i = 0; i < NUM_BTN; i++) begin
      owner_onehot[i] = (owner == i[IDX_W-1:0]);
    end
  end

  // Release takes priority over repeat, so at most one event pulse fires per cycle.
  always_ff @(posedge clk_65mhz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= '0;
      hold_cnt    <= '0;
      repeating   <= 1'b0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_repeat  <= '0;
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      btn_repeat  <= '0;
      case (state)
        IDLE: begin
          hold_cnt  <= '0;
          repeating <= 1'b0;
          if (rise_any) begin
            owner     <= rise_idx;
            btn_press <= rise_first;
            state     <= OWNED;
          end
        end
        OWNED: begin
          if (fall[owner]) begin
            btn_release <= owner_onehot;
            owner       <= '0;
            hold_cnt    <= '0;
            repeating   <= 1'b0;
            state       <= IDLE;
          end else if (REPEAT_MASK[owner]) begin
            if (hold_cnt == (repeating ? REP_LAST : HOLD_LAST)) begin
              btn_repeat <= owner_onehot;
              hold_cnt   <= '0;
              repeating  <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HC_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == OWNED);
  assign btn_held = busy ? (owner_onehot & btn_level) : '0;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/hold/repeat times;
// every expected vector is hand-derived from the edge count since the input change.
module tb_button_conditioner;

  logic       clk_65mhz;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_held;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [3:0] btn_repeat;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  button_conditioner #(
    .NUM_BTN        (4),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3),
    .REPEAT_MASK    (4'b0011)
  ) dut (
    .clk_65mhz  (clk_65mhz),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_held   (btn_held),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat),
    .busy       (busy)
  );

  initial clk_65mhz = 1'b0;
  always #5 clk_65mhz = ~clk_65mhz;

  // Inputs change on the falling edge; the bench then advances whole cycles.
  task automatic applyStimulus(input logic [3:0] raw, input int cycles);
    btn_raw = raw;
    repeat (cycles) @(negedge clk_65mhz);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] e_level,
                             input logic [3:0] e_held, input logic [3:0] e_press,
                             input logic [3:0] e_release, input logic [3:0] e_repeat,
                             input logic e_busy);
    logic [20:0] obs;
    logic [20:0] exp;
    obs = {btn_level, btn_held, btn_press, btn_release, btn_repeat, busy};
    exp = {e_level, e_held, e_press, e_release, e_repeat, e_busy};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed lvl=%b held=%b press=%b rel=%b rep=%b busy=%b, expected lvl=%b held=%b press=%b rel=%b rep=%b busy=%b",
             tag, btn_level, btn_held, btn_press, btn_release, btn_repeat, busy,
             e_level, e_held, e_press, e_release, e_repeat, e_busy);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    btn_raw = 4'b0000;
    #2;
    checkOutput("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk_65mhz);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 5);
    checkOutput("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Clean up press, then held long enough to auto-repeat
    applyStimulus(4'b0001, 5);
    checkOutput("up_before_level", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0001, 1);
    checkOutput("up_level", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0001, 1);
    checkOutput("up_press", 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0001, 1);
    checkOutput("up_press_single", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0001, 8);
    checkOutput("up_before_repeat", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0001, 1);
    checkOutput("up_repeat_p10", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    applyStimulus(4'b0001, 1);
    checkOutput("up_repeat_gap", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0001, 2);
    checkOutput("up_repeat_p13", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    applyStimulus(4'b0001, 3);
    checkOutput("up_repeat_p16", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    applyStimulus(4'b0000, 3);
    checkOutput("up_repeat_p19", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    applyStimulus(4'b0000, 2);
    checkOutput("up_release_pending", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 1);
    checkOutput("up_level_fall", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    applyStimulus(4'b0000, 1);
    checkOutput("up_release", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 1);
    checkOutput("up_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Bouncing next button
    applyStimulus(4'b0100, 1);
    applyStimulus(4'b0000, 1);
    applyStimulus(4'b0100, 1);
    applyStimulus(4'b0000, 1);
    applyStimulus(4'b0100, 5);
    checkOutput("bounce_no_level", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0100, 1);
    checkOutput("bounce_level", 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0100, 1);
    checkOutput("bounce_press", 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0100, 1);
    checkOutput("bounce_owned", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Reset while next is owned and still held
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk_65mhz);
    rst_n = 1'b1;
    applyStimulus(4'b0100, 12);
    checkOutput("held_after_reset", 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 8);
    checkOutput("released_after_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0100, 6);
    checkOutput("repress_level", 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0100, 1);
    checkOutput("repress_press", 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 6);
    checkOutput("next_level_fall", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 1);
    checkOutput("next_release", 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 1);
    checkOutput("next_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Chord: up then down two cycles later
    applyStimulus(4'b0001, 2);
    applyStimulus(4'b0011, 5);
    checkOutput("chord_press", 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0011, 1);
    checkOutput("chord_second_ignored", 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0010, 6);
    checkOutput("chord_owner_fall", 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0010, 1);
    checkOutput("chord_release", 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    applyStimulus(4'b0010, 4);
    checkOutput("chord_no_press", 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 8);
    checkOutput("chord_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Simultaneous rise on down and set: lowest index wins
    applyStimulus(4'b1010, 6);
    checkOutput("simul_level", 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b1010, 1);
    checkOutput("simul_press", 4'b1010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 6);
    checkOutput("simul_level_fall", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 1);
    checkOutput("simul_release", 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 1);
    checkOutput("simul_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Set button held 25 cycles: repeat is masked off
    applyStimulus(4'b1000, 7);
    checkOutput("set_press", 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b1);
    for (int n = 0; n < 25; n++) begin
      applyStimulus(4'b1000, 1);
      checkOutput($sformatf("set_no_repeat_%0d", n), 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    end
    applyStimulus(4'b0000, 7);
    checkOutput("set_release", 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 1);
    checkOutput("set_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
